ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 32 KiB RAM and its memory-mapped registers (prescaler, switches, buttons).
- Port A is the CPU; port B is the DMA/boot-loader path.
- Serialises requests, drives the RAM read/write strobes and address/data, holds the address through the read latency, and returns read data with a valid pulse to the winning port.
- Round-robin arbitration guarantees neither port starves.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arbiter_if.sv | 28 ++
 rtl/ram_arbiter.sv | 85 ++++++++
 tb/tb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and the round-robin pick function for ram_arbiter.
package ram_arb_pkg;
   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
   typedef enum logic {PORT_A, PORT_B} port_e;

   typedef struct packed {
      logic  valid;
      port_e id;
   } pick_t;

   // A held lock hands the slot to B (or to nobody if B is not asking).
   function automatic pick_t rr_pick(input logic a_req, b_req, last_b, lock);
      pick_t p;
      p.valid = lock ? b_req : (a_req | b_req);
      p.id    = (lock || !a_req || (b_req && !last_b)) ? PORT_B : PORT_A;
      return p;
   endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester ports A/B plus the RAM-side bus; slave is the arbiter's view.
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();
   logic              a_req, a_we, a_gnt, a_rvalid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata, a_rdata;
   logic              b_req, b_we, b_gnt, b_rvalid, b_lock;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata, b_rdata;
   logic              ram_read, ram_write;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_di, ram_do;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, b_lock, ram_do,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             ram_read, ram_write, ram_address, ram_di
   );
   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, b_lock, ram_do,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             ram_read, ram_write, ram_address, ram_di
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter/sequencer for the single-port RAM and its mapped registers.
// Define RAM_ARB_LOCK_EN to let port B hold the RAM across a burst via b_lock.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int READ_LAT = 1
) (
   input logic          mem_clk,
   input logic          mem_reset,
   ram_arbiter_if.slave bus
);
   state_e            state_q;
   port_e             win_q;
   logic              we_q, last_b_q;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, a_rdata_q, b_rdata_q;
   logic              lock, idle, done, sel_b;
   pick_t             pick;

`ifdef RAM_ARB_LOCK_EN
   assign lock = bus.b_lock & last_b_q;
`else
   logic unused_b_lock;
   assign unused_b_lock = bus.b_lock;
   assign lock          = 1'b0;
`endif

   assign pick  = rr_pick(bus.a_req, bus.b_req, last_b_q, lock);
   assign sel_b = pick.id == PORT_B;
   assign idle  = state_q == IDLE;
   assign done  = (state_q == WAIT) && (cnt_q == 2'd0);

   assign bus.a_gnt     = idle & pick.valid & ~sel_b;
   assign bus.b_gnt     = idle & pick.valid & sel_b;
   assign bus.a_rvalid  = done & (win_q == PORT_A);
   assign bus.b_rvalid  = done & (win_q == PORT_B);
   // Read data is forwarded in the valid cycle and held afterwards.
   assign bus.a_rdata   = bus.a_rvalid ? bus.ram_do : a_rdata_q;
   assign bus.b_rdata   = bus.b_rvalid ? bus.ram_do : b_rdata_q;
   assign bus.ram_read  = (state_q == ISSUE) & ~we_q;
   assign bus.ram_write = (state_q == ISSUE) & we_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_di      = wdata_q;

   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         state_q   <= IDLE;
         win_q     <= PORT_A;
         we_q      <= 1'b0;
         last_b_q  <= 1'b1;
         cnt_q     <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick.valid) begin
               state_q  <= ISSUE;
               win_q    <= pick.id;
               we_q     <= sel_b ? bus.b_we : bus.a_we;
               addr_q   <= sel_b ? bus.b_addr : bus.a_addr;
               wdata_q  <= sel_b ? bus.b_wdata : bus.a_wdata;
               last_b_q <= sel_b;
            end
            ISSUE: begin
               state_q <= we_q ? IDLE : WAIT;
               cnt_q   <= 2'(READ_LAT - 1);
            end
            WAIT: begin
               cnt_q <= cnt_q - 2'd1;
               if (cnt_q == 2'd0) begin
                  state_q <= IDLE;
                  if (win_q == PORT_B) b_rdata_q <= bus.ram_do;
                  else a_rdata_q <= bus.ram_do;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiters (READ_LAT 1 and 3) on a shared RAM model with a mapped switch register.
module tb_ram_arbiter;
   logic mem_clk = 0, mem_reset = 1;
   logic [7:0] sw1 = 8'hC3;
   int pass_n = 0, check_n = 0;

   typedef struct {bit pb; logic [7:0] d;} sb_t;
   typedef struct {bit pb; bit we; logic [14:0] addr; logic [7:0] wd; logic [7:0] ex;} vec_t;
   sb_t  q1[$], q3[$];
   sb_t  e1, e3;
   vec_t tbl[8];

   ram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) b1();
   ram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) b3();
   ram_arbiter #(.ADDR_W(15), .DATA_W(8), .READ_LAT(1)) u1(.mem_clk(mem_clk), .mem_reset(mem_reset), .bus(b1));
   ram_arbiter #(.ADDR_W(15), .DATA_W(8), .READ_LAT(3)) u3(.mem_clk(mem_clk), .mem_reset(mem_reset), .bus(b3));

   always #5 mem_clk = ~mem_clk;

   function automatic logic [7:0] pre(input logic [14:0] a);
      return a[7:0] ^ a[14:7];
   endfunction

   logic [7:0] mem [0:32767];
   logic [7:0] d1, p3 [3];
   always @(posedge mem_clk) begin
      if (mem_reset) for (int i = 0; i < 32768; i++) mem[i] <= pre(15'(i));
      else begin
         if (b1.ram_write) mem[b1.ram_address] <= b1.ram_di;
         if (b3.ram_write) mem[b3.ram_address] <= b3.ram_di;
      end
      if (b1.ram_read) d1 <= mem[b1.ram_address];
      if (b3.ram_read) p3[0] <= mem[b3.ram_address];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign b1.ram_do = (b1.ram_address == 15'h7FFE) ? sw1 : d1;
   assign b3.ram_do = (b3.ram_address == 15'h7FFE) ? sw1 : p3[2];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      check_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
   endtask

   // Scoreboard: every rvalid must match the oldest expected read for that DUT.
   always @(negedge mem_clk) if (!mem_reset) begin
      chk("excl1", {b1.a_gnt & b1.b_gnt, b1.ram_read & b1.ram_write}, 0);
      chk("excl3", {b3.a_gnt & b3.b_gnt, b3.ram_read & b3.ram_write}, 0);
      if (b1.a_rvalid | b1.b_rvalid) begin
         if (q1.size() == 0) chk("sb1_unexpected", {b1.a_rvalid, b1.b_rvalid}, 0);
         else begin
            e1 = q1.pop_front();
            chk("sb1_port", {b1.a_rvalid, b1.b_rvalid}, e1.pb ? 2'b01 : 2'b10);
            chk("sb1_data", b1.b_rvalid ? b1.b_rdata : b1.a_rdata, e1.d);
         end
      end
      if (b3.a_rvalid | b3.b_rvalid) begin
         if (q3.size() == 0) chk("sb3_unexpected", {b3.a_rvalid, b3.b_rvalid}, 0);
         else begin
            e3 = q3.pop_front();
            chk("sb3_port", {b3.a_rvalid, b3.b_rvalid}, e3.pb ? 2'b01 : 2'b10);
            chk("sb3_data", b3.b_rvalid ? b3.b_rdata : b3.a_rdata, e3.d);
         end
      end
   end

   task automatic rst_chk(input string t);
      chk({t, "_ctl1"}, {b1.a_gnt, b1.b_gnt, b1.a_rvalid, b1.b_rvalid, b1.ram_read, b1.ram_write}, 0);
      chk({t, "_bus1"}, {b1.ram_address, b1.ram_di}, 0);
      chk({t, "_rd1"}, {b1.a_rdata, b1.b_rdata}, 0);
      chk({t, "_ctl3"}, {b3.a_gnt, b3.b_gnt, b3.a_rvalid, b3.b_rvalid, b3.ram_read, b3.ram_write}, 0);
      chk({t, "_bus3"}, {b3.ram_address, b3.ram_di}, 0);
      chk({t, "_rd3"}, {b3.a_rdata, b3.b_rdata}, 0);
   endtask

   task automatic xact1(input vec_t v);
      @(posedge mem_clk); #1;
      if (v.pb) begin b1.b_req = 1; b1.b_we = v.we; b1.b_addr = v.addr; b1.b_wdata = v.wd; end
      else begin b1.a_req = 1; b1.a_we = v.we; b1.a_addr = v.addr; b1.a_wdata = v.wd; end
      @(negedge mem_clk);
      chk("tbl_gnt", {b1.a_gnt, b1.b_gnt}, v.pb ? 2'b01 : 2'b10);
      if (!v.we) q1.push_back('{v.pb, v.ex});
      @(posedge mem_clk); #1;
      b1.a_req = 0; b1.b_req = 0;
      @(negedge mem_clk);
      chk("tbl_issue", {b1.ram_read, b1.ram_write, b1.ram_address}, {~v.we, v.we, v.addr});
      if (v.we) chk("tbl_di", b1.ram_di, v.wd);
      else begin
         @(negedge mem_clk);
         chk("tbl_wait", {b1.ram_read, b1.ram_write, b1.a_rvalid, b1.b_rvalid, b1.ram_address},
             {2'b00, ~v.pb, v.pb, v.addr});
      end
   endtask

   initial begin
      int g, na, nb, seen;
      tbl[0] = '{0, 1, 15'h0123, 8'h5A, 8'h00};
      tbl[1] = '{0, 0, 15'h0123, 8'h00, 8'h5A};
      tbl[2] = '{1, 1, 15'h0456, 8'hA5, 8'h00};
      tbl[3] = '{1, 0, 15'h0456, 8'h00, 8'hA5};
      tbl[4] = '{0, 1, 15'h7FFF, 8'hE7, 8'h00};
      tbl[5] = '{0, 0, 15'h7FFF, 8'h00, 8'hE7};
      tbl[6] = '{0, 0, 15'h0005, 8'h00, 8'h05};
      tbl[7] = '{1, 0, 15'h7FFE, 8'h00, 8'hC3};
      {b1.a_req, b1.a_we, b1.a_addr, b1.a_wdata, b1.b_req, b1.b_we, b1.b_addr, b1.b_wdata, b1.b_lock} = '0;
      {b3.a_req, b3.a_we, b3.a_addr, b3.a_wdata, b3.b_req, b3.b_we, b3.b_addr, b3.b_wdata, b3.b_lock} = '0;
      repeat (3) @(posedge mem_clk);
      @(negedge mem_clk);
      rst_chk("reset");
      mem_reset = 0;
      repeat (2) @(negedge mem_clk);
      rst_chk("idle");

      foreach (tbl[i]) xact1(tbl[i]);
      @(negedge mem_clk);
      chk("rdata_hold", {b1.a_rdata, b1.b_rdata}, {8'h05, 8'hC3});

      // Both ports stream reads: grants must alternate A,B,A,B,A,B.
      g = 0; na = 0; nb = 0;
      @(posedge mem_clk); #1;
      b1.a_req = 1; b1.a_we = 0; b1.a_addr = 15'h0100;
      b1.b_req = 1; b1.b_we = 0; b1.b_addr = 15'h0200;
      for (int c = 0; c < 60 && g < 6; c++) begin
         @(negedge mem_clk);
         if (b1.a_gnt | b1.b_gnt) begin
            chk("rr_order", b1.b_gnt, g % 2);
            if (b1.b_gnt) begin q1.push_back('{1, pre(b1.b_addr)}); nb++; end
            else begin q1.push_back('{0, pre(b1.a_addr)}); na++; end
            g++;
         end
         @(posedge mem_clk); #1;
         b1.a_addr = 15'h0100 + 15'(na); b1.a_req = na < 3;
         b1.b_addr = 15'h0200 + 15'(nb); b1.b_req = nb < 3;
      end
      chk("rr_grants", g, 6);
      repeat (4) @(negedge mem_clk);
      chk("rr_drain", q1.size(), 0);

`ifdef RAM_ARB_LOCK_EN
      g = 0;
      @(posedge mem_clk); #1;
      b1.b_lock = 1; b1.a_req = 1; b1.b_req = 1; b1.b_addr = 15'h0300;
      for (int c = 0; c < 60 && g < 3; c++) begin
         @(negedge mem_clk);
         if (b1.a_gnt | b1.b_gnt) begin
            chk("lock_b", {b1.a_gnt, b1.b_gnt}, 2'b01);
            q1.push_back('{1, pre(b1.b_addr)});
            g++;
         end
         @(posedge mem_clk); #1;
         b1.b_addr = 15'h0300 + 15'(g); b1.b_req = g < 3;
      end
      chk("lock_grants", g, 3);
      seen = 0;
      repeat (6) begin @(negedge mem_clk); if (b1.a_gnt) seen++; end
      chk("lock_hold", seen, 0);
      @(posedge mem_clk); #1;
      b1.b_lock = 0;
      @(negedge mem_clk);
      chk("lock_release", {b1.a_gnt, b1.b_gnt}, 2'b10);
      q1.push_back('{0, pre(b1.a_addr)});
      @(posedge mem_clk); #1;
      b1.a_req = 0;
`else
      @(posedge mem_clk); #1;
      b1.b_lock = 1; b1.a_req = 1; b1.b_req = 1;
      @(negedge mem_clk);
      chk("nolock_a", {b1.a_gnt, b1.b_gnt}, 2'b10);
      q1.push_back('{0, pre(b1.a_addr)});
      @(posedge mem_clk); #1;
      b1.a_req = 0;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge mem_clk);
         if (b1.b_gnt) begin seen = 1; q1.push_back('{1, pre(b1.b_addr)}); end
         @(posedge mem_clk); #1;
         if (seen != 0) b1.b_req = 0;
      end
      chk("nolock_b", seen, 1);
      b1.b_lock = 0;
`endif
      repeat (4) @(negedge mem_clk);
      chk("lock_drain", q1.size(), 0);

      // READ_LAT=3: address held for all four post-grant cycles, rvalid on the fourth.
      @(posedge mem_clk); #1;
      b3.a_req = 1; b3.a_we = 0; b3.a_addr = 15'h0321;
      @(negedge mem_clk);
      chk("l3_gnt", {b3.a_gnt, b3.b_gnt}, 2'b10);
      q3.push_back('{0, pre(15'h0321)});
      @(posedge mem_clk); #1;
      b3.a_req = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge mem_clk);
         chk("l3_addr", b3.ram_address, 15'h0321);
         chk("l3_ctl", {b3.ram_read, b3.a_rvalid}, {k == 1, k == 4});
      end
      @(posedge mem_clk); #1;
      b3.b_req = 1; b3.b_we = 0; b3.b_addr = 15'h7FFE;
      @(negedge mem_clk);
      chk("l3_gnt_b", {b3.a_gnt, b3.b_gnt}, 2'b01);
      q3.push_back('{1, 8'hC3});
      @(posedge mem_clk); #1;
      b3.b_req = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge mem_clk);
         chk("l3_sw_addr", b3.ram_address, 15'h7FFE);
         chk("l3_sw_rv", b3.b_rvalid, k == 4);
      end
      @(negedge mem_clk);
      chk("l3_drain", q3.size(), 0);

      // Reset while u1 is in ISSUE: strobe must drop within the same cycle.
      @(posedge mem_clk); #1;
      b1.a_req = 1; b1.a_we = 0; b1.a_addr = 15'h0010;
      @(negedge mem_clk);
      chk("ri_gnt", b1.a_gnt, 1);
      @(posedge mem_clk); #1;
      b1.a_req = 0;
      chk("ri_read", b1.ram_read, 1);
      mem_reset = 1; #1;
      chk("ri_drop", {b1.ram_read, b1.ram_write, b1.ram_address}, 0);
      @(posedge mem_clk); @(negedge mem_clk);
      rst_chk("ri_state");
      mem_reset = 0;

      // Reset while u3 waits on a read: that read must never complete.
      @(posedge mem_clk); #1;
      b3.a_req = 1; b3.a_we = 0; b3.a_addr = 15'h0033;
      @(negedge mem_clk);
      chk("rw_gnt", b3.a_gnt, 1);
      @(posedge mem_clk); #1;
      b3.a_req = 0;
      @(posedge mem_clk); #1;
      chk("rw_addr", b3.ram_address, 15'h0033);
      mem_reset = 1; #1;
      chk("rw_drop", {b3.ram_read, b3.ram_write, b3.a_rvalid, b3.ram_address}, 0);
      @(posedge mem_clk); @(negedge mem_clk);
      mem_reset = 0;
      seen = 0;
      repeat (6) begin @(negedge mem_clk); if (b3.a_rvalid | b1.a_rvalid) seen++; end
      chk("rw_norvalid", seen, 0);
      chk("final_q", q1.size() + q3.size(), 0);

      $display("%0d/%0d checks passed", pass_n, check_n);
      $finish;
   end
endmodule
